// File: rtl/pipeline_run_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_run_pkg
// Shared definitions for the pipeline run controller:
//   - run_state_t : controller state encoding (IDLE=0, INIT=1, RUN=2, DONE=3)
//   - STOP_W      : width of the stop_reason field
//   - STOP_*      : stop_reason codes (NONE, LIMIT, HALT, BKPT)
// -----------------------------------------------------------------------------
package pipeline_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_t;

  localparam int unsigned STOP_W = 2;

  localparam logic [STOP_W-1:0] STOP_NONE  = 2'd0;
  localparam logic [STOP_W-1:0] STOP_LIMIT = 2'd1;
  localparam logic [STOP_W-1:0] STOP_HALT  = 2'd2;
  localparam logic [STOP_W-1:0] STOP_BKPT  = 2'd3;

endpackage

// File: rtl/pipeline_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_run_ctrl_if
// Control/status bundle between a host (master) and the run controller (slave).
//   master -> slave : start, step_mode, step, halt_req
//                     (+ pc, bkpt_pc, bkpt_valid when RUN_CTRL_BKPT_EN is defined)
//   slave -> master : cpu_rst, cpu_en, cycle_cnt[CNT_W], running, done,
//                     stop_reason[STOP_W]
// Optional feature macro: RUN_CTRL_BKPT_EN (adds the breakpoint signals).
// -----------------------------------------------------------------------------
interface pipeline_run_ctrl_if
  import pipeline_run_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic              start;
  logic              step_mode;
  logic              step;
  logic              halt_req;
  logic              cpu_rst;
  logic              cpu_en;
  logic [CNT_W-1:0]  cycle_cnt;
  logic              running;
  logic              done;
  logic [STOP_W-1:0] stop_reason;

`ifdef RUN_CTRL_BKPT_EN
  logic [31:0]       pc;
  logic [31:0]       bkpt_pc;
  logic              bkpt_valid;

  modport master (
    output start, step_mode, step, halt_req, pc, bkpt_pc, bkpt_valid,
    input  cpu_rst, cpu_en, cycle_cnt, running, done, stop_reason
  );

  modport slave (
    input  start, step_mode, step, halt_req, pc, bkpt_pc, bkpt_valid,
    output cpu_rst, cpu_en, cycle_cnt, running, done, stop_reason
  );
`else
  modport master (
    output start, step_mode, step, halt_req,
    input  cpu_rst, cpu_en, cycle_cnt, running, done, stop_reason
  );

  modport slave (
    input  start, step_mode, step, halt_req,
    output cpu_rst, cpu_en, cycle_cnt, running, done, stop_reason
  );
`endif

endinterface

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   clear : synchronous clear to zero (wins over inc)
//   inc   : advance by one unless already saturated
//   count : registered count value [WIDTH]
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_run_ctrl
// Sequences the pipeline core through reset, an INIT_CYCLES reset hold and a
// bounded (RUN_CYCLES) or unbounded run, in free-run or single-step mode.
// Counts enabled cycles and records why the run stopped.
//   Parameters : INIT_CYCLES (>=1), RUN_CYCLES (0 = unlimited), CNT_W
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : pipeline_run_ctrl_if.slave (start/step/halt in,
//                cpu_rst/cpu_en/cycle_cnt/running/done/stop_reason out)
// Optional feature macro: RUN_CTRL_BKPT_EN (PC breakpoint stop, reason BKPT).
// -----------------------------------------------------------------------------
module pipeline_run_ctrl
  import pipeline_run_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 5,
  parameter int unsigned RUN_CYCLES  = 24,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_run_ctrl_if.slave  bus
);

  // The hold counter only has to reach INIT_CYCLES-1.
  localparam int unsigned INIT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam bit                LIMIT_EN  = (RUN_CYCLES != 0);
  // Stop is decided while the final enabled cycle is in progress, i.e. when
  // the count is one short of the limit.
  localparam logic [CNT_W-1:0]  LIMIT_M1  = CNT_W'(RUN_CYCLES - 1);

  run_state_t        state_reg;
  logic              cpu_rst_reg;
  logic              cpu_en_reg;
  logic              running_reg;
  logic              done_reg;
  logic [STOP_W-1:0] reason_reg;

  logic [CNT_W-1:0]  cycle_cnt;
  logic [INIT_W-1:0] init_cnt;

  logic start_accept;
  logic cnt_clear;
  logic halt_hit;
  logic bkpt_hit;
  logic limit_hit;
  logic en_next;

  assign start_accept = bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign cnt_clear    = rst || start_accept;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .clear (cnt_clear),
    .inc   (cpu_en_reg),
    .count (cycle_cnt)
  );

  sat_counter #(
    .WIDTH (INIT_W)
  ) u_init_cnt (
    .clk   (clk),
    .clear (cnt_clear),
    .inc   (state_reg == ST_INIT),
    .count (init_cnt)
  );

  assign halt_hit  = bus.halt_req;
`ifdef RUN_CTRL_BKPT_EN
  assign bkpt_hit  = cpu_en_reg && bus.bkpt_valid && (bus.pc == bus.bkpt_pc);
`else
  assign bkpt_hit  = 1'b0;
`endif
  assign limit_hit = LIMIT_EN && cpu_en_reg && (cycle_cnt == LIMIT_M1);

  // Step mode grants exactly one enabled cycle per sampled step.
  assign en_next   = !bus.step_mode || bus.step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cpu_rst_reg <= 1'b1;
      cpu_en_reg  <= 1'b0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      reason_reg  <= STOP_NONE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            state_reg <= ST_INIT;
          end
        end

        ST_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state_reg   <= ST_RUN;
            cpu_rst_reg <= 1'b0;
            cpu_en_reg  <= en_next;
            running_reg <= 1'b1;
          end
        end

        ST_RUN: begin
          if (halt_hit || bkpt_hit || limit_hit) begin
            state_reg   <= ST_DONE;
            cpu_en_reg  <= 1'b0;
            running_reg <= 1'b0;
            done_reg    <= 1'b1;
            if (halt_hit) begin
              reason_reg <= STOP_HALT;
            end else if (bkpt_hit) begin
              reason_reg <= STOP_BKPT;
            end else begin
              reason_reg <= STOP_LIMIT;
            end
          end else begin
            cpu_en_reg <= en_next;
          end
        end

        ST_DONE: begin
          // Core is left out of reset so its state can be inspected.
          if (bus.start) begin
            state_reg   <= ST_INIT;
            cpu_rst_reg <= 1'b1;
            done_reg    <= 1'b0;
            reason_reg  <= STOP_NONE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_rst     = cpu_rst_reg;
  assign bus.cpu_en      = cpu_en_reg;
  assign bus.cycle_cnt   = cycle_cnt;
  assign bus.running     = running_reg;
  assign bus.done        = done_reg;
  assign bus.stop_reason = reason_reg;

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Run controller that sequences the MIPS `PIPELINE` core through reset, a parameterised initialisation hold, and a bounded or unbounded run, with free-run and single-step modes. It sits between the system clock/reset and the core. It drives the core's reset and clock-enable, counts executed cycles, and reports why execution stopped. This replaces the fixed wait-then-toggle bring-up with a reusable, cycle-exact sequencer.

## Interface
- `INIT_CYCLES`, default 5: cycles the core is held in reset after `start` (≥1).
- `RUN_CYCLES`, default 24: enabled cycles before automatic stop; 0 = unlimited.
- `CNT_W`, default 16: width of `cycle_cnt` (must hold `RUN_CYCLES`).
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run (sampled in IDLE/DONE only).
- `step_mode` in 1: 1 = single-step, 0 = free-run.
- `step` in 1: single-step request, one enabled cycle per sampled high cycle.
- `halt_req` in 1: stop request.
- `cpu_rst` out 1: reset to the core (active-high).
- `cpu_en` out 1: clock-enable to the core.
- `cycle_cnt` out CNT_W: enabled cycles since the last `start`.
- `running` out 1: state is RUN.
- `done` out 1: state is DONE.
- `stop_reason` out 2: 0 NONE, 1 LIMIT, 2 HALT, 3 BKPT.

## Operation
- States: IDLE, INIT, RUN, DONE.
- Reset values: state IDLE, `cpu_rst`=1, `cpu_en`=0, `cycle_cnt`=0, `running`=0, `done`=0, `stop_reason`=0.
- IDLE: `cpu_rst`=1. `start`=1 → INIT.
- INIT: `cpu_rst`=1 for exactly `INIT_CYCLES` cycles, then RUN. `start` is ignored.
- RUN: `cpu_rst`=0.
  - Free-run: `cpu_en`=1 every cycle.
  - Step mode: `cpu_en`=1 only in the cycle after each cycle in which `step`=1.
  - `step_mode` may change at any time and takes effect on the next edge.
- `cycle_cnt` increments on every cycle in which `cpu_en`=1. It saturates at all-ones and never wraps.
- Stop conditions, evaluated each RUN cycle:
  - `halt_req`=1 → DONE, reason HALT.
  - Breakpoint (when configured) → DONE, reason BKPT.
  - `RUN_CYCLES`≠0 and an enabled cycle brings `cycle_cnt` to `RUN_CYCLES` → DONE, reason LIMIT.
  - Priority: HALT > BKPT > LIMIT.
- DONE: `cpu_en`=0 and `cpu_rst`=0, so core state is preserved for inspection. `cycle_cnt` and `stop_reason` hold. `start`=1 → INIT, clearing `cycle_cnt`, `stop_reason` and `done`.
- `rst` at any time returns to the reset values on the next edge, overriding all other inputs.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- `start` sampled at edge N → `cpu_rst` still 1 through edge N+`INIT_CYCLES`. First `cpu_en`=1 is in the cycle after edge N+`INIT_CYCLES`.
- With defaults, free-run, no halt: exactly 24 `cpu_en` cycles. `done` rises on the same edge that drops the 24th `cpu_en`.
- `halt_req` sampled at edge M → `cpu_en`=0 and `done`=1 after edge M. No further enabled cycle occurs.
- `step` held high for K cycles → K enabled cycles, each lagging its `step` cycle by one.
- `halt_req` together with the final LIMIT cycle → reason HALT.

## Configuration
- `RUN_CTRL_BKPT_EN` defined: adds ports `pc` (in, 32), `bkpt_pc` (in, 32) and `bkpt_valid` (in, 1).
  - In RUN, a cycle with `cpu_en`=1, `bkpt_valid`=1 and `pc`==`bkpt_pc` is the last enabled cycle.
  - The next edge enters DONE with reason BKPT.
- Undefined: these ports are absent, no breakpoint logic exists, and reason 3 is never produced.

## Structure
- Package `pipeline_run_pkg` holds:
  - the state encoding constants (IDLE=0, INIT=1, RUN=2, DONE=3);
  - the `stop_reason` codes;
  - the `stop_reason` width.
- One sub-module, `sat_counter` (parameter width; inputs clear and inc; saturating output), used for both the INIT hold counter and `cycle_cnt`.

## Test plan
- Default parameters, `start` pulse, free-run → 5 cycles of `cpu_rst`=1, then exactly 24 `cpu_en` cycles; `done`=1, `stop_reason`=1, `cycle_cnt`=24.
- `halt_req` after 10 enabled cycles → `cycle_cnt`=10, `stop_reason`=2, `cpu_en` low from the following cycle.
- `step_mode`=1 with 3 isolated `step` pulses, then 2 cycles of `step` held high → 5 enabled cycles, each one cycle after its `step`, `cycle_cnt`=5, `running` still 1.
- `RUN_CYCLES`=0, `CNT_W`=4, free-run for 20 cycles → `cycle_cnt` saturates at 15 and `done` stays 0.
- `rst` asserted mid-RUN, then `start` from DONE after a completed run → reset values after `rst`; after `start`, `cycle_cnt` and `stop_reason` clear to 0 and INIT is repeated.
- `RUN_CTRL_BKPT_EN` defined, `bkpt_pc`=0x0000_0010, `pc` stepping by 4 from 0 → stops after the enabled cycle with `pc`=0x10, `cycle_cnt`=5, `stop_reason`=3.
